// File: rtl/ram_sweep_initiator_if.sv
// Request/response bus between the sweep initiator and a single-port RAM.
// One request outstanding; read data returns on rsp_valid.
interface ram_sweep_initiator_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] Data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   modport master (
      output req_valid, req_write, Addr, Data,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, Addr, Data,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/ram_sweep_initiator.sv
// ram_sweep_initiator: writes data(a)=a^SEED to 0..MAX_ADDR, reads back, counts mismatches.
// Define RAM_SWEEP_ASSERT_EN to compile in bus protocol assertions.
module ram_sweep_initiator #(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(8'hFF),
   parameter logic [DATA_W-1:0] SEED     = DATA_W'(8'hA5)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  pass_o,
   output logic [7:0]            err_count_o,
   ram_sweep_initiator_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD_REQ,
      S_RD_WAIT,
      S_FIN
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [7:0]        err_q, err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              vld_q, vld_d;
   logic              wr_q, wr_d;

   function automatic logic [DATA_W-1:0] pattern(
      input logic [ADDR_W-1:0] a
   );
      return DATA_W'(a) ^ SEED;
   endfunction

   logic last_addr;
   logic rsp_bad;

   assign last_addr = (addr_q == MAX_ADDR);
   assign rsp_bad   = (bus.rsp_data != pattern(addr_q));

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      vld_d   = vld_q;
      wr_d    = wr_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_WR;
               addr_d  = '0;
               data_d  = pattern('0);
               err_d   = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               vld_d   = 1'b1;
               wr_d    = 1'b1;
            end
         end

         S_WR: begin
            if (vld_q && bus.req_ready) begin
               if (last_addr) begin
                  state_d = S_RD_REQ;
                  addr_d  = '0;
                  data_d  = '0;
                  wr_d    = 1'b0;
               end else begin
                  addr_d = addr_q + 1'b1;
                  data_d = pattern(addr_q + 1'b1);
               end
            end
         end

         S_RD_REQ: begin
            if (bus.req_ready) begin
               state_d = S_RD_WAIT;
               vld_d   = 1'b0;
            end
         end

         S_RD_WAIT: begin
            if (bus.rsp_valid) begin
               if (rsp_bad && (err_q != 8'hFF)) begin
                  err_d = err_q + 8'd1;
               end
               if (last_addr) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_RD_REQ;
                  addr_d  = addr_q + 1'b1;
                  vld_d   = 1'b1;
               end
            end
         end

         // err_q is final here, so pass and done land together
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pass_d  = (err_q == 8'd0);
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         vld_q   <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         vld_q   <= vld_d;
         wr_q    <= wr_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign pass_o        = pass_q;
   assign err_count_o   = err_q;
   assign bus.req_valid = vld_q;
   assign bus.req_write = wr_q;
   assign bus.Addr      = addr_q;
   assign bus.Data      = data_q;

`ifdef RAM_SWEEP_ASSERT_EN
   a_addr_range: assert property (
      @(posedge clk) disable iff (rst)
      bus.req_valid |-> (bus.Addr <= MAX_ADDR)
   ) else $error("ram_sweep: Addr beyond MAX_ADDR");

   a_req_hold: assert property (
      @(posedge clk) disable iff (rst)
      (bus.req_valid && !bus.req_ready) |=>
         ($stable({bus.Addr, bus.Data, bus.req_write}) && bus.req_valid)
   ) else $error("ram_sweep: request changed or dropped while stalled");

   a_rsp_state: assert property (
      @(posedge clk) disable iff (rst)
      bus.rsp_valid |-> (state_q == S_RD_WAIT)
   ) else $error("ram_sweep: rsp_valid outside RD_WAIT");
`else
   // no protocol assertions in this build; datapath is unchanged
`endif

endmodule
